spectrum_frame_sink: RTL and testbench

- Consumer end of the STFT display-write interface (disp_wr_en / disp_wr_idx / disp_wr_data).
- Converts each complex bin to an approximate magnitude and stores it in a ping-pong bin buffer.
- Once a full frame has been captured, streams the frame in bin order to the display/column renderer over a valid/ready handshake.

---
 rtl/spectrum_frame_sink.sv | 132 +++++++++++++
 tb/tb_spectrum_frame_sink.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_frame_sink.sv
// Captures complex STFT bins as max+min/2 magnitudes into a ping-pong buffer and streams each complete frame in bin order.
// First beat 3 cycles after the idx FFT_SIZE-1 input; stalls hold outputs; a frame finishing while the previous one is still streaming is dropped.
module spectrum_frame_sink #(
  parameter int WORD_WIDTH = 16,
  parameter int FFT_SIZE   = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        disp_wr_en,
  input  logic [$clog2(FFT_SIZE)-1:0] disp_wr_idx,
  input  logic [2*WORD_WIDTH-1:0]     disp_wr_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FFT_SIZE)-1:0] out_idx,
  output logic [WORD_WIDTH-1:0]       out_mag,
  output logic                        out_last,
  output logic                        frame_drop,
  output logic                        busy
);
  localparam int AW = $clog2(FFT_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t r_state, w_state_nxt;

  logic [WORD_WIDTH-1:0] w_re, w_im, w_abs_re, w_abs_im, w_max, w_min, w_mag;
  logic                  r_m_vld;
  logic [AW-1:0]         r_m_idx;
  logic [WORD_WIDTH-1:0] r_m_mag;
  logic [WORD_WIDTH-1:0] r_mem [0:2*FFT_SIZE-1];
  logic                  r_wr_bank, r_rd_bank, r_rd_done;
  logic [AW-1:0]         r_rd_addr;
  logic                  w_swap_req, w_last_hs, w_accept, w_drop;
  logic                  w_fetch, w_fetch_bank;
  logic [AW-1:0]         w_fetch_addr;

  // |x| of the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign w_re     = disp_wr_data[2*WORD_WIDTH-1:WORD_WIDTH];
  assign w_im     = disp_wr_data[WORD_WIDTH-1:0];
  assign w_abs_re = w_re[WORD_WIDTH-1] ? (~w_re) + WORD_WIDTH'(1) : w_re;
  assign w_abs_im = w_im[WORD_WIDTH-1] ? (~w_im) + WORD_WIDTH'(1) : w_im;
  assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
  assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
  assign w_mag    = w_max + (w_min >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_vld <= 1'b0;
      r_m_idx <= '0;
      r_m_mag <= '0;
    end else begin
      r_m_vld <= disp_wr_en;
      r_m_idx <= disp_wr_idx;
      r_m_mag <= w_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (r_m_vld) r_mem[{r_wr_bank, r_m_idx}] <= r_m_mag;
  end

  assign w_swap_req = r_m_vld && (r_m_idx == LAST_IDX);
  assign w_last_hs  = out_valid && out_ready && out_last;
  assign w_accept   = w_swap_req && ((r_state == S_IDLE) || w_last_hs);
  assign w_drop     = w_swap_req && !w_accept;
  assign busy       = (r_state == S_STREAM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A swap coinciding with the final beat fetches bin 0 of the new bank directly, so the stream has no gap.
  always_comb begin
    w_state_nxt  = r_state;
    w_fetch      = 1'b0;
    w_fetch_bank = r_rd_bank;
    w_fetch_addr = r_rd_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (w_accept) begin
          w_fetch      = 1'b1;
          w_fetch_bank = r_wr_bank;
          w_fetch_addr = '0;
        end else begin
          if (w_last_hs) w_state_nxt = S_IDLE;
          if ((!out_valid || out_ready) && !r_rd_done) w_fetch = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_done  <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_mag    <= '0;
      out_last   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= w_drop;
      if (w_accept) begin
        r_wr_bank <= ~r_wr_bank;
        r_rd_bank <= r_wr_bank;
      end
      if (w_accept && (r_state == S_IDLE)) begin
        r_rd_addr <= '0;
        r_rd_done <= 1'b0;
      end else if (w_fetch) begin
        r_rd_addr <= w_fetch_addr + AW'(1);
        r_rd_done <= (w_fetch_addr == LAST_IDX);
      end
      if (w_fetch) begin
        out_valid <= 1'b1;
        out_idx   <= w_fetch_addr;
        out_mag   <= r_mem[{w_fetch_bank, w_fetch_addr}];
        out_last  <= (w_fetch_addr == LAST_IDX);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spectrum_frame_sink.sv
// Directed bench for spectrum_frame_sink: latency, magnitude, stall, drop, back-to-back swap and mid-stream reset.
module tb_spectrum_frame_sink;
  localparam int W  = 16;
  localparam int N  = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_wr_en;
  logic [AW-1:0] disp_wr_idx;
  logic [2*W-1:0] disp_wr_data;
  logic          out_valid, out_ready, out_last, frame_drop, busy;
  logic [AW-1:0] out_idx;
  logic [W-1:0]  out_mag;

  spectrum_frame_sink #(.WORD_WIDTH(W), .FFT_SIZE(N)) dut (
    .clk(clk), .reset(reset), .disp_wr_en(disp_wr_en), .disp_wr_idx(disp_wr_idx),
    .disp_wr_data(disp_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_mag(out_mag), .out_last(out_last),
    .frame_drop(frame_drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int q_idx[$];
  int q_mag[$];
  bit q_last[$];
  int q_cyc[$];
  int drop_cnt = 0;
  int valid_seen = 0;
  int busy_falls = 0;
  int busy_fall_cyc = -1;
  bit busy_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_idx.push_back(int'(out_idx));
      q_mag.push_back(int'(out_mag));
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if (frame_drop) drop_cnt++;
    if (out_valid) valid_seen++;
    if (busy_d && !busy) begin
      busy_falls++;
      busy_fall_cyc = cyc;
    end
    busy_d = busy;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q_idx.delete(); q_mag.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic wr_bin(input int idx, input int re, input int im);
    disp_wr_en   = 1'b1;
    disp_wr_idx  = AW'(idx);
    disp_wr_data = {16'(re), 16'(im)};
    tick;
  endtask

  task automatic write_frame(input int p);
    for (int i = 0; i < N; i++) wr_bin(i, p * 1000 + i, 0);
    disp_wr_en = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (q_idx.size() < n && t < budget) begin
      tick;
      t++;
    end
  endtask

  function automatic int sp_re(input int k);
    case (k)
      5: return -32768; 6: return 3; 7: return -7; 8: return 100;
      9: return 32767; 10: return -1; default: return 0;
    endcase
  endfunction

  function automatic int sp_im(input int k);
    case (k)
      5: return -32768; 6: return -4; 7: return 2; 8: return -300;
      9: return 32767; 10: return -1; 11: return -32768; default: return 0;
    endcase
  endfunction

  function automatic int sp_mag(input int k);
    case (k)
      5: return 49152; 6: return 5; 7: return 8; 8: return 350;
      9: return 49150; 10: return 1; 11: return 32768; default: return 0;
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b1; disp_wr_en = 1'b0; disp_wr_idx = '0; disp_wr_data = '0; out_ready = 1'b0;
    repeat (3) tick;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_idx !== 8'd0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    vectors++; if (out_mag !== 16'd0) begin miscompares++; $display("FAIL reset_mag: got %0d want 0", out_mag); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", out_last); end
    vectors++; if (frame_drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop: got %b want 0", frame_drop); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (2) tick;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_basic_frame;
    out_ready = 1'b1;
    clear_q();
    write_frame(0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL lat_t1: valid=%b want 0", out_valid); end
    tick;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL lat_t2: valid=%b busy=%b want 0 1", out_valid, busy); end
    tick;
    vectors++; if (out_valid !== 1'b1 || out_idx !== 8'd0) begin miscompares++; $display("FAIL lat_t3: valid=%b idx=%0d want 1 0", out_valid, out_idx); end
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL basic_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== k || q_last[k] !== (k == N - 1) || q_cyc[k] !== q_cyc[0] + k) begin
        miscompares++;
        $display("FAIL basic_beat%0d: idx=%0d mag=%0d last=%0b cyc=+%0d want idx=%0d mag=%0d last=%0b cyc=+%0d",
                 k, q_idx[k], q_mag[k], q_last[k], q_cyc[k] - q_cyc[0], k, k, (k == N - 1), k);
      end
    end
    repeat (3) tick;
    vectors++;
    if (busy !== 1'b0 || q_cyc.size() < N || busy_fall_cyc != q_cyc[N-1] + 1) begin
      miscompares++;
      $display("FAIL basic_busy_fall: busy=%b fall_cyc=%0d want 0 and last_beat_cyc+1", busy, busy_fall_cyc);
    end
  endtask

  task automatic test_magnitude;
    out_ready = 1'b1;
    clear_q();
    wr_bin(5, 1000, 1000);
    disp_wr_en = 1'b0;
    tick;
    for (int k = N - 2; k >= 0; k--) begin
      wr_bin(k, sp_re(k), sp_im(k));
      if (k % 16 == 0) begin
        disp_wr_en = 1'b0;
        tick;
      end
    end
    wr_bin(N - 1, 0, 0);
    disp_wr_en = 1'b0;
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL mag_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== sp_mag(k)) begin
        miscompares++;
        $display("FAIL mag_bin%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k, sp_mag(k));
      end
    end
    repeat (3) tick;
  endtask

  task automatic test_stall;
    bit found = 1'b0;
    out_ready = 1'b1;
    clear_q();
    write_frame(1);
    for (int t = 0; t < 400 && !found; t++) begin
      tick;
      if (out_valid && out_idx == 8'd17) found = 1'b1;
    end
    out_ready = 1'b0;
    vectors++; if (!found) begin miscompares++; $display("FAIL stall_reach17: bin 17 never presented, want presented"); end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 8'd17 || out_mag !== 16'd1017 || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: valid=%b idx=%0d mag=%0d last=%b want 1 17 1017 0", c, out_valid, out_idx, out_mag, out_last);
      end
      tick;
    end
    out_ready = 1'b1;
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL stall_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== 1000 + k) begin
        miscompares++;
        $display("FAIL stall_beat%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k, 1000 + k);
      end
    end
    repeat (3) tick;
  endtask

  task automatic test_drop;
    int drop0;
    out_ready = 1'b0;
    clear_q();
    write_frame(2);
    repeat (3) tick;
    vectors++; if (out_valid !== 1'b1 || out_idx !== 8'd0 || out_mag !== 16'd2000) begin miscompares++; $display("FAIL drop_first_stalled: valid=%b idx=%0d mag=%0d want 1 0 2000", out_valid, out_idx, out_mag); end
    drop0 = drop_cnt;
    write_frame(3);
    repeat (3) tick;
    vectors++; if (drop_cnt != drop0 + 1) begin miscompares++; $display("FAIL drop_pulse: got %0d pulses want 1", drop_cnt - drop0); end
    vectors++; if (out_valid !== 1'b1 || out_idx !== 8'd0 || out_mag !== 16'd2000) begin miscompares++; $display("FAIL drop_still_held: valid=%b idx=%0d mag=%0d want 1 0 2000", out_valid, out_idx, out_mag); end
    out_ready = 1'b1;
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL drop_a_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== 2000 + k) begin
        miscompares++;
        $display("FAIL drop_a_beat%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k, 2000 + k);
      end
    end
    repeat (4) tick;
    clear_q();
    write_frame(4);
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL drop_c_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== 4000 + k) begin
        miscompares++;
        $display("FAIL drop_c_beat%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k, 4000 + k);
      end
    end
    repeat (3) tick;
    vectors++; if (drop_cnt != drop0 + 1) begin miscompares++; $display("FAIL drop_total: got %0d pulses want 1", drop_cnt - drop0); end
  endtask

  task automatic test_back_to_back;
    int drop0, falls0;
    out_ready = 1'b1;
    clear_q();
    drop0  = drop_cnt;
    falls0 = busy_falls;
    write_frame(5);
    for (int i = 0; i < N - 1; i++) wr_bin(i, 6000 + i, 0);
    disp_wr_en = 1'b0;
    tick;
    wr_bin(N - 1, 6000 + N - 1, 0);
    disp_wr_en = 1'b0;
    wait_beats(2 * N, 700);
    repeat (3) tick;
    vectors++; if (q_idx.size() != 2 * N) begin miscompares++; $display("FAIL b2b_count: got %0d beats want %0d", q_idx.size(), 2 * N); end
    for (int k = 0; k < 2 * N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k % N || q_mag[k] !== ((k < N) ? 5000 + k : 6000 + k - N)) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k % N, (k < N) ? 5000 + k : 6000 + k - N);
      end
    end
    vectors++;
    if (q_cyc.size() < N + 1 || q_cyc[N] != q_cyc[N-1] + 1) begin
      miscompares++;
      $display("FAIL b2b_no_gap: new frame bin 0 not on the cycle after the old last beat (beats=%0d)", q_cyc.size());
    end
    vectors++; if (drop_cnt != drop0) begin miscompares++; $display("FAIL b2b_no_drop: got %0d pulses want 0", drop_cnt - drop0); end
    vectors++; if (busy_falls != falls0 + 1) begin miscompares++; $display("FAIL b2b_busy_falls: got %0d want 1", busy_falls - falls0); end
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    int vs0;
    out_ready = 1'b1;
    clear_q();
    write_frame(7);
    for (int t = 0; t < 400 && !found; t++) begin
      tick;
      if (out_valid && out_idx == 8'd100) found = 1'b1;
    end
    reset = 1'b1;
    #1;
    vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_reach100: bin 100 never presented, want presented"); end
    vectors++;
    if (out_valid !== 1'b0 || out_idx !== 8'd0 || out_mag !== 16'd0 || out_last !== 1'b0 || frame_drop !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: valid=%b idx=%0d mag=%0d last=%b drop=%b busy=%b want all 0", out_valid, out_idx, out_mag, out_last, frame_drop, busy);
    end
    repeat (2) tick;
    reset = 1'b0;
    vs0 = valid_seen;
    repeat (20) tick;
    vectors++; if (valid_seen != vs0) begin miscompares++; $display("FAIL rstmid_no_resume: got %0d valid cycles want 0", valid_seen - vs0); end
    for (int i = 0; i <= 100; i++) wr_bin(i, 9, 0);
    disp_wr_en = 1'b0;
    repeat (10) tick;
    vectors++; if (valid_seen != vs0) begin miscompares++; $display("FAIL rstmid_partial: got %0d valid cycles want 0", valid_seen - vs0); end
    clear_q();
    write_frame(8);
    wait_beats(N, 400);
    vectors++; if (q_idx.size() != N) begin miscompares++; $display("FAIL rstmid_count: got %0d beats want %0d", q_idx.size(), N); end
    for (int k = 0; k < N && k < q_idx.size(); k++) begin
      vectors++;
      if (q_idx[k] !== k || q_mag[k] !== 8000 + k) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d: idx=%0d mag=%0d want idx=%0d mag=%0d", k, q_idx[k], q_mag[k], k, 8000 + k);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_magnitude();
    test_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
